// File: rtl/mapa_ram.sv
// -----------------------------------------------------------------------------
// mapa_ram -- tile map storage for the snake game.
//
// Holds a MAPA_WIDTH x MAPA_HEIGHT grid of 4-bit cell codes:
//   0000 NADA (empty), 0001 OBSTACULO, 0010 FRUTA, 1 s dd snake
//   (s = snake id, dd = tail direction).
// The map is wiped by a one-cell-per-clock sweep after reset and on every
// clear_req. The sweep visits cells in row-major order starting at (0,0).
// The VGA read port and the game read/write ports run concurrently, with no
// stalls. Reads are read-before-write with respect to a same-edge write.
//
// Ports
//   clk                      system clock, rising edge
//   reset                    asynchronous, active-high reset
//   vga_read, vga_x, vga_y   VGA read strobe and cell coordinates
//   mapa_R/G/B               registered cell colour (held while vga_read=0)
//   wr_en, wr_x, wr_y, wr_data   game write port
//   rd_en, rd_x, rd_y        game read request
//   rd_data, rd_valid        game read response (1-cycle latency)
//   clear_req                start a clear sweep (new game)
//   busy                     clear sweep in progress
//   collision                1-cycle pulse after a snake write hits an
//                            obstacle or a snake cell
//
// Build option
//   MAPA_COLLISION_EN        when defined, generates the collision detector;
//                            otherwise collision is tied to 0.
// -----------------------------------------------------------------------------
module mapa_ram #(
    parameter int MAPA_WIDTH  = 40,
    parameter int MAPA_HEIGHT = 30
) (
    input  logic       clk,
    input  logic       reset,

    input  logic       vga_read,
    input  logic [9:0] vga_x,
    input  logic [9:0] vga_y,
    output logic [1:0] mapa_R,
    output logic [1:0] mapa_G,
    output logic [1:0] mapa_B,

    input  logic       wr_en,
    input  logic [9:0] wr_x,
    input  logic [9:0] wr_y,
    input  logic [3:0] wr_data,

    input  logic       rd_en,
    input  logic [9:0] rd_x,
    input  logic [9:0] rd_y,
    output logic [3:0] rd_data,
    output logic       rd_valid,

    input  logic       clear_req,
    output logic       busy,
    output logic       collision
);

    localparam int DEPTH = MAPA_WIDTH * MAPA_HEIGHT;
    // A 1x1 map still needs a 1-bit address.
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [AW-1:0] LAST_CELL = AW'(DEPTH - 1);
    localparam logic [10:0]   W_LIM     = 11'(MAPA_WIDTH);
    localparam logic [10:0]   H_LIM     = 11'(MAPA_HEIGHT);

    localparam logic [3:0] CODE_NADA      = 4'b0000;
    localparam logic [3:0] CODE_OBSTACULO = 4'b0001;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    function automatic logic in_range(input logic [9:0] x, input logic [9:0] y);
        return ({1'b0, x} < W_LIM) && ({1'b0, y} < H_LIM);
    endfunction

    // Row-major address y*MAPA_WIDTH+x. The 21-bit intermediate holds the
    // largest in-range product (1023*1024+1023) so nothing wraps; callers
    // only use the result when the coordinates are in range.
    function automatic logic [AW-1:0] cell_addr(input logic [9:0] x,
                                                input logic [9:0] y);
        return AW'(21'(y) * 21'(MAPA_WIDTH) + 21'(x));
    endfunction

    // Cell code to {R,G,B}, 2 bits per channel.
    function automatic logic [5:0] cell_colour(input logic [3:0] code);
        logic [5:0] rgb;
        casez (code)
            4'b0001: rgb = 6'b11_00_00;   // obstacle: red
            4'b0010: rgb = 6'b00_11_00;   // fruit: green
            4'b10??: rgb = 6'b00_00_11;   // snake 0: blue
            4'b11??: rgb = 6'b11_11_00;   // snake 1: yellow
            default: rgb = 6'b00_00_00;
        endcase
        return rgb;
    endfunction

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   sweep_cnt;

    logic [3:0]      mem [DEPTH];

    logic [AW-1:0]   wr_addr;
    logic [AW-1:0]   rd_addr;
    logic [AW-1:0]   vga_addr;
    logic            wr_ok;

    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [3:0]      mem_wdata;

    assign wr_addr  = cell_addr(wr_x, wr_y);
    assign rd_addr  = cell_addr(rd_x, rd_y);
    assign vga_addr = cell_addr(vga_x, vga_y);

    // Game writes are only accepted in IDLE; during a sweep they are dropped.
    assign wr_ok = (state == IDLE) && wr_en && in_range(wr_x, wr_y);

    // -------------------------------------------------------------------------
    // FSM: state register and sweep counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= CLEAR;
            sweep_cnt <= '0;
        end else begin
            state <= state_next;
            // The counter rests at 0 in IDLE so each new sweep starts at (0,0).
            if (state == CLEAR && sweep_cnt != LAST_CELL)
                sweep_cnt <= sweep_cnt + AW'(1);
            else
                sweep_cnt <= '0;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            CLEAR: if (sweep_cnt == LAST_CELL) state_next = IDLE;
            IDLE:  if (clear_req)              state_next = CLEAR;
            default: state_next = CLEAR;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy = (state == CLEAR);
    end

    // -------------------------------------------------------------------------
    // Storage write port, shared by the sweep and the game writer. The
    // ~reset term discards a write that lands on an edge while reset is held.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_we    = wr_ok;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (state == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = sweep_cnt;
            mem_wdata = CODE_NADA;
        end
        if (reset)
            mem_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    // -------------------------------------------------------------------------
    // Game read port: rd_valid follows every rd_en; rd_data holds between reads.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                if (!busy && in_range(rd_x, rd_y))
                    rd_data <= mem[rd_addr];
                else
                    rd_data <= CODE_NADA;
            end
        end
    end

    // -------------------------------------------------------------------------
    // VGA read port: colours update only on vga_read and hold otherwise.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {mapa_R, mapa_G, mapa_B} <= '0;
        end else if (vga_read) begin
            if (!busy && in_range(vga_x, vga_y))
                {mapa_R, mapa_G, mapa_B} <= cell_colour(mem[vga_addr]);
            else
                {mapa_R, mapa_G, mapa_B} <= '0;
        end
    end

    // -------------------------------------------------------------------------
    // Collision detector: looks at the old contents of the cell being written
    // on the same edge the write commits.
    // -------------------------------------------------------------------------
`ifdef MAPA_COLLISION_EN
    logic [3:0] old_code;

    assign old_code = mem[wr_addr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            collision <= 1'b0;
        else
            collision <= wr_ok && wr_data[3] &&
                         (old_code == CODE_OBSTACULO || old_code[3]);
    end
`else
    assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_mapa_ram.sv
// -----------------------------------------------------------------------------
// tb_mapa_ram -- directed self-checking bench for mapa_ram (40x30 map).
// Expected values are hand-derived constants. Collision expectations follow
// the MAPA_COLLISION_EN build option.
// -----------------------------------------------------------------------------
module tb_mapa_ram;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       vga_read = 1'b0;
    logic [9:0] vga_x = '0;
    logic [9:0] vga_y = '0;
    logic [1:0] mapa_R, mapa_G, mapa_B;
    logic       wr_en = 1'b0;
    logic [9:0] wr_x = '0;
    logic [9:0] wr_y = '0;
    logic [3:0] wr_data = '0;
    logic       rd_en = 1'b0;
    logic [9:0] rd_x = '0;
    logic [9:0] rd_y = '0;
    logic [3:0] rd_data;
    logic       rd_valid;
    logic       clear_req = 1'b0;
    logic       busy;
    logic       collision;

    int total = 0;
    int bad   = 0;

`ifdef MAPA_COLLISION_EN
    localparam logic COLL_EXP = 1'b1;
`else
    localparam logic COLL_EXP = 1'b0;
`endif

    mapa_ram #(.MAPA_WIDTH(40), .MAPA_HEIGHT(30)) dut (
        .clk      (clk),
        .reset    (reset),
        .vga_read (vga_read),
        .vga_x    (vga_x),
        .vga_y    (vga_y),
        .mapa_R   (mapa_R),
        .mapa_G   (mapa_G),
        .mapa_B   (mapa_B),
        .wr_en    (wr_en),
        .wr_x     (wr_x),
        .wr_y     (wr_y),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_x     (rd_x),
        .rd_y     (rd_y),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .clear_req(clear_req),
        .busy     (busy),
        .collision(collision)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_cell(input int x, input int y, input logic [3:0] d);
        wr_en = 1'b1; wr_x = 10'(x); wr_y = 10'(y); wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd_cell(input int x, input int y, output logic [3:0] d, output logic v);
        rd_en = 1'b1; rd_x = 10'(x); rd_y = 10'(y);
        tick();
        d = rd_data; v = rd_valid;
        rd_en = 1'b0;
    endtask

    task automatic vga_cell(input int x, input int y, output logic [5:0] c);
        vga_read = 1'b1; vga_x = 10'(x); vga_y = 10'(y);
        tick();
        c = {mapa_R, mapa_G, mapa_B};
        vga_read = 1'b0;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (busy && n < 5000) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] d;
        logic       v;
        logic [5:0] c;
        logic [3:0] sd;
        logic       sv;
        int         n;
        int         errs;

        sd = '0; sv = 1'b0;

        // Reset state, checked before any clock edge.
        #2 reset = 1'b1;
        #1;
        check("rst_busy", busy, 1);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_colour", {mapa_R, mapa_G, mapa_B}, 0);
        check("rst_collision", collision, 0);
        tick(); tick();
        reset = 1'b0;

        // Initial sweep length and contents.
        wait_busy(n);
        check("sweep_len", n, 1200);
        errs = 0;
        for (int y = 0; y < 30; y++)
            for (int x = 0; x < 40; x++) begin
                rd_cell(x, y, d, v);
                if (d !== 4'b0000 || v !== 1'b1) errs++;
            end
        check("clear_all", errs, 0);
        tick();
        check("rd_valid_pulse", rd_valid, 0);

        // Fruit at (10,10).
        wr_cell(10, 10, 4'b0010);
        rd_cell(10, 10, d, v);
        check("fruit_valid", v, 1);
        check("fruit_data", d, 4'b0010);
        vga_cell(10, 10, c);
        check("fruit_colour", c, 6'b00_11_00);
        vga_x = 10'd0; vga_y = 10'd0;
        tick();
        check("colour_hold", {mapa_R, mapa_G, mapa_B}, 6'b00_11_00);

        // Out-of-range writes and reads.
        wr_cell(40, 0, 4'b0001);
        wr_cell(0, 30, 4'b0001);
        rd_cell(40, 0, d, v);
        check("oor_rd_data", d, 0);
        check("oor_rd_valid", v, 1);
        rd_cell(0, 1, d, v);
        check("oor_no_wrap_x", d, 0);
        rd_cell(0, 29, d, v);
        check("oor_no_wrap_y", d, 0);
        vga_cell(0, 30, c);
        check("oor_vga_black", c, 0);

        // Same-cycle read and write of (3,3).
        wr_cell(3, 3, 4'b0010);
        wr_en = 1'b1; wr_x = 10'd3; wr_y = 10'd3; wr_data = 4'b1100;
        rd_en = 1'b1; rd_x = 10'd3; rd_y = 10'd3;
        vga_read = 1'b1; vga_x = 10'd3; vga_y = 10'd3;
        tick();
        wr_en = 1'b0; rd_en = 1'b0; vga_read = 1'b0;
        check("rbw_rd_old", rd_data, 4'b0010);
        check("rbw_vga_old", {mapa_R, mapa_G, mapa_B}, 6'b00_11_00);
        rd_cell(3, 3, d, v);
        check("rbw_rd_new", d, 4'b1100);
        vga_cell(3, 3, c);
        check("snake1_colour", c, 6'b11_11_00);

        // Remaining colour codes.
        wr_cell(4, 4, 4'b1001);
        vga_cell(4, 4, c);
        check("snake0_colour", c, 6'b00_00_11);
        wr_cell(6, 6, 4'b0011);
        vga_cell(6, 6, c);
        check("unused_colour", c, 0);
        wr_cell(5, 5, 4'b0001);
        vga_cell(5, 5, c);
        check("obstacle_colour", c, 6'b11_00_00);

        // Collision: snake onto obstacle, then snake onto fruit.
        wr_cell(5, 5, 4'b1000);
        check("coll_obstacle", collision, COLL_EXP);
        tick();
        check("coll_one_cycle", collision, 0);
        rd_cell(5, 5, d, v);
        check("coll_write_commits", d, 4'b1000);
        wr_cell(10, 10, 4'b1000);
        check("coll_fruit", collision, 0);

        // Clear sweep: ignored clear_req, dropped write, masked read.
        wr_cell(5, 5, 4'b0001);
        wr_cell(39, 29, 4'b0010);
        clear_req = 1'b1;
        tick();
        check("clear_busy", busy, 1);
        n = 0;
        while (busy && n < 5000) begin
            n++;
            clear_req = (n < 4);
            if (n == 1000) begin
                wr_en = 1'b1; wr_x = 10'd7; wr_y = 10'd7; wr_data = 4'b0010;
                rd_en = 1'b1; rd_x = 10'd39; rd_y = 10'd29;
            end
            tick();
            wr_en = 1'b0; rd_en = 1'b0;
            if (n == 1000) begin
                sd = rd_data; sv = rd_valid;
            end
        end
        clear_req = 1'b0;
        check("clear_len", n, 1200);
        check("busy_rd_valid", sv, 1);
        check("busy_rd_data", sd, 0);
        rd_cell(5, 5, d, v);
        check("clear_wiped", d, 0);
        rd_cell(7, 7, d, v);
        check("busy_write_lost", d, 0);
        rd_cell(39, 29, d, v);
        check("clear_last_cell", d, 0);

        // Asynchronous reset from IDLE with live outputs.
        wr_cell(1, 1, 4'b0010);
        rd_en = 1'b1; rd_x = 10'd1; rd_y = 10'd1;
        vga_read = 1'b1; vga_x = 10'd1; vga_y = 10'd1;
        tick();
        rd_en = 1'b0; vga_read = 1'b0;
        check("pre_rst_valid", rd_valid, 1);
        check("pre_rst_colour", {mapa_R, mapa_G, mapa_B}, 6'b00_11_00);
        #2 reset = 1'b1;
        #1;
        check("async_busy", busy, 1);
        check("async_rd_valid", rd_valid, 0);
        check("async_rd_data", rd_data, 0);
        check("async_colour", {mapa_R, mapa_G, mapa_B}, 0);
        tick();
        reset = 1'b0;

        // Reset mid-sweep restarts the full sweep.
        for (int i = 0; i < 600; i++) tick();
        check("mid_sweep_busy", busy, 1);
        #2 reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_busy(n);
        check("restart_len", n, 1200);
        rd_cell(1, 1, d, v);
        check("restart_wiped", d, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
